// File: rtl/median_stream_ctrl.sv
// Frame-level sequencer for the 3x3 median-filter datapath: counts raster pixels,
// drives line-buffer push/pop strobes and flags pixels with a fully-inside window.
module median_stream_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  output logic             push,
  output logic             pop,
  output logic             win_valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             busy,
  output logic             frame_done
);

  localparam int FILL_W = $clog2(2*IMG_W+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  logic [COL_W-1:0]    col_cnt;
  logic [ROW_W-1:0]    row_cnt;
  logic [FILL_W-1:0]   fill_cnt;
  logic                last_col;
  logic                last_row;
  logic                fill_last;
  logic [COL_W-1:0]    col_next;
  logic [ROW_W-1:0]    row_next;

  assign last_col  = (col_cnt == COL_W'(IMG_W-1));
  assign last_row  = (row_cnt == ROW_W'(IMG_H-1));
  assign fill_last = (fill_cnt == FILL_W'(2*IMG_W-1));

  // Raster position of the pixel after the current one; wraps at end of frame.
  always_comb begin
    col_next = col_cnt + COL_W'(1);
    row_next = row_cnt;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : row_cnt + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      col_cnt    <= '0;
      row_cnt    <= '0;
      fill_cnt   <= '0;
      push       <= 1'b0;
      pop        <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      push       <= 1'b0;
      pop        <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state    <= S_FILL;
            busy     <= 1'b1;
            col_cnt  <= '0;
            row_cnt  <= '0;
            fill_cnt <= '0;
          end
        end
        S_FILL: begin
          if (pix_valid) begin
            push     <= 1'b1;
            col      <= col_cnt;
            row      <= row_cnt;
            col_cnt  <= col_next;
            row_cnt  <= row_next;
            fill_cnt <= fill_cnt + FILL_W'(1);
            if (fill_last)
              state <= S_RUN;
          end
        end
        S_RUN: begin
          if (pix_valid) begin
            push      <= 1'b1;
            pop       <= 1'b1;
            win_valid <= (col_cnt >= COL_W'(2));
            col       <= col_cnt;
            row       <= row_cnt;
            col_cnt   <= col_next;
            row_cnt   <= row_next;
            // Last pixel's strobes and frame_done land together in the DONE cycle.
            if (last_col && last_row) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Randomized bench for median_stream_ctrl (4x4 frame) against a pixel-index
// reference model, plus per-frame tallies pinned to hand-computed values.
module tb_median_stream_ctrl;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       push, pop, win_valid, busy, frame_done;
  logic [1:0] col, row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  median_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .push(push), .pop(pop), .win_valid(win_valid), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a run of W*H accepted pixels indexed k; each
  // output is a plain function of k, plus one trailing busy cycle.
  bit m_active, m_done;
  int k;
  int e_push, e_pop, e_win, e_fd, e_busy, e_col, e_row;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_done = 0; k = 0;
      e_push = 0; e_pop = 0; e_win = 0; e_fd = 0; e_busy = 0; e_col = 0; e_row = 0;
    end else begin
      e_push = 0; e_pop = 0; e_win = 0; e_fd = 0;
      if (m_done) begin
        m_done = 0;
        e_busy = 0;
      end else if (m_active) begin
        if (pix_valid) begin
          e_push = 1;
          e_col  = k % W;
          e_row  = k / W;
          e_pop  = (k >= 2*W) ? 1 : 0;
          e_win  = ((k / W) >= 2 && (k % W) >= 2) ? 1 : 0;
          if (k == W*H-1) begin
            e_fd = 1; m_active = 0; m_done = 1;
          end
          k++;
        end
      end else if (start) begin
        m_active = 1; k = 0; e_busy = 1;
      end
    end
  end

  // Compare process plus per-frame tallies.
  int n_push = 0, n_pop = 0, n_win = 0, first_pop = -1, n_frames = 0;
  int win_mask = 0;

  always @(negedge clk) begin
    chk("push", push, e_push);
    chk("pop", pop, e_pop);
    chk("win_valid", win_valid, e_win);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
    chk("col", col, e_col);
    chk("row", row, e_row);
    chk("pop_without_push", int'(pop & ~push), 0);
    if (reset) begin
      n_push = 0; n_pop = 0; n_win = 0; first_pop = -1; win_mask = 0;
    end else begin
      if (pop && first_pop < 0) first_pop = n_push;
      if (win_valid) begin
        win_mask = win_mask | (1 << n_push);
        n_win++;
      end
      if (pop) n_pop++;
      if (push) n_push++;
      if (frame_done) begin
        n_frames++;
        chk("frame_pushes", n_push, 16);
        chk("frame_pops", n_pop, 8);
        chk("frame_wins", n_win, 4);
        chk("first_pop_index", first_pop, 8);
        chk("win_index_mask", win_mask, 32'hCC00);
        n_push = 0; n_pop = 0; n_win = 0; first_pop = -1; win_mask = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gap_pct, input bit rnd_start);
    int acc;
    int guard;
    bit pv;
    acc = 0;
    guard = 0;
    start = 1'b1;
    pix_valid = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    while (acc < W*H && guard < 400) begin
      pv = ($urandom_range(99) >= gap_pct);
      pix_valid = pv;
      start = rnd_start ? ($urandom_range(3) == 0) : 1'b0;
      tick();
      if (pv) acc++;
      guard++;
    end
    chk("frame_stimulus_bound", int'(guard < 400), 1);
    start = 1'b0;
    pix_valid = 1'($urandom_range(1));
    tick();
    pix_valid = 1'b0;
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", busy, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("reset_push", push, 0);
    chk("reset_busy", busy, 0);
    chk("reset_col", col, 0);
    reset = 1'b0;
    tick();

    // Continuous frame
    run_frame(0, 1'b0);

    // Alternating gaps
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pix_valid = (i % 2 == 0);
      tick();
    end
    pix_valid = 1'b0; tick();
    chk("gapped_busy_after", busy, 0);

    // start together with a pixel in IDLE: that pixel is dropped
    start = 1'b1; pix_valid = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    pix_valid = 1'b0; tick();
    chk("start_pixel_dropped_busy", busy, 0);

    // Asynchronous reset mid-RUN, after pixel 10
    start = 1'b1; tick(); start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_reset_push", push, 1);
    chk("pre_reset_col", col, 2);
    chk("pre_reset_row", row, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_push", push, 0);
    chk("async_pop", pop, 0);
    chk("async_win", win_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_col", col, 0);
    chk("async_row", row, 0);
    pix_valid = 1'b0;
    tick();
    reset = 1'b0;
    run_frame(30, 1'b1);

    // start pulses while busy, pixel offered during DONE
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pix_valid = 1'b1;
      start = (i == 5 || i == 12 || i == 16);
      tick();
    end
    start = 1'b0; pix_valid = 1'b0;
    tick();

    // Back-to-back frames
    run_frame(0, 1'b0);
    run_frame(0, 1'b0);

    for (int f = 0; f < 20; f++) run_frame(int'($urandom_range(60)), 1'b1);
    chk("frame_count", n_frames, 27);

    // Free-running random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(9) == 0);
      pix_valid = 1'($urandom_range(1));
      if ($urandom_range(299) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end else begin
        tick();
      end
    end
    start = 1'b0;
    pix_valid = 1'b1;
    wait_idle(200);
    pix_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
